// File: rtl/eth_mii_pkg.sv
// Shared definitions for the MII-style frame generator and checker:
// control-character codes, receive FSM states and error classes.
package eth_mii_pkg;

    localparam logic [7:0] CODE_IDLE  = 8'h07;
    localparam logic [7:0] CODE_START = 8'hFB;
    localparam logic [7:0] CODE_EOF   = 8'hFD;
    localparam logic [7:0] CODE_DATA  = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_RUNT     = 3'd1,
        ERR_OVERSIZE = 3'd2,
        ERR_BAD_DATA = 3'd3,
        ERR_BAD_CTRL = 3'd4
    } err_code_t;

    // Payload cycles are 8 bytes each; lengths are reported in bytes.
    function automatic logic [15:0] cycles_to_bytes(input logic [15:0] cycles);
        return {cycles[12:0], 3'b000};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance on request, but stick at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/frame_checker.sv
// Receive-side frame checker: delimits frames on START/EOF control words,
// checks payload length and content, and reports one registered verdict
// per frame together with running good/bad totals.
module frame_checker
    import eth_mii_pkg::*;
#(
    parameter int         DATA_WIDTH      = 64,
    parameter int         CTRL_WIDTH      = 8,
    parameter logic [7:0] IDLE_CODE       = CODE_IDLE,
    parameter logic [7:0] START_CODE      = CODE_START,
    parameter logic [7:0] EOF_CODE        = CODE_EOF,
    parameter logic [7:0] DATA_PATTERN    = CODE_DATA,
    parameter int         MIN_DATA_CYCLES = 5,
    parameter int         MAX_DATA_CYCLES = 17
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_frame_valid,
    output logic                  o_frame_err,
    output logic [2:0]            o_err_code,
    output logic [15:0]           o_frame_len,
    output logic [15:0]           o_good_cnt,
    output logic [15:0]           o_bad_cnt
);

    localparam int          LANES        = DATA_WIDTH / 8;
    localparam logic [15:0] MIN_CYC      = 16'(MIN_DATA_CYCLES);
    localparam logic [15:0] MAX_CYC      = 16'(MAX_DATA_CYCLES);
    localparam logic [15:0] OVERSIZE_LEN = 16'((MAX_DATA_CYCLES + 1) * 8);

    // Input decode
    logic             rx_is_ctrl;
    logic             rx_start;
    logic             rx_eof;
    logic             rx_bad_byte;
    logic             rx_idle_unused;
    logic [LANES-1:0] lane_bad;
    logic [7:0]       lane_first;
    logic [7:0]       lane_last;

    // State and registered outputs
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        derr_q, derr_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
    err_code_t   err_code_q, err_code_d;
    logic [15:0] frame_len_q, frame_len_d;

    assign lane_first = i_rx_data[7:0];
    assign lane_last  = i_rx_data[DATA_WIDTH-1 -: 8];
    assign rx_is_ctrl = |i_rx_ctrl;
    assign rx_start   = rx_is_ctrl && (lane_first == START_CODE);
    // START wins when a word carries both delimiters.
    assign rx_eof     = rx_is_ctrl && !rx_start && (lane_last == EOF_CODE);
    // Idle and unknown control words get identical treatment; the idle
    // decode is kept only as a named probe for debug.
    assign rx_idle_unused = rx_is_ctrl && (lane_first == IDLE_CODE);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_bad[l] = (i_rx_data[l*8 +: 8] != DATA_PATTERN);
    end
    assign rx_bad_byte = |lane_bad;

    // Next-state, counter and report decision for the current input word.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        derr_d        = derr_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_len_d   = frame_len_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_start) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    derr_d  = 1'b0;
                end
            end

            ST_DATA: begin
                if (!rx_is_ctrl) begin
                    if (cnt_q == MAX_CYC) begin
                        // One payload cycle too many: reject now and
                        // swallow the rest of the frame in DROP.
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVERSIZE;
                        frame_len_d = OVERSIZE_LEN;
                        state_d     = ST_DROP;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        derr_d = derr_q | rx_bad_byte;
                    end
                end else if (rx_start) begin
                    // Abort the open frame and reopen in the same cycle.
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_BAD_CTRL;
                    frame_len_d = cycles_to_bytes(cnt_q);
                    cnt_d       = '0;
                    derr_d      = 1'b0;
                end else if (rx_eof) begin
                    frame_len_d = cycles_to_bytes(cnt_q);
                    state_d     = ST_IDLE;
                    if (cnt_q < MIN_CYC) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_RUNT;
                    end else if (derr_q) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_BAD_DATA;
                    end else begin
                        frame_valid_d = 1'b1;
                        err_code_d    = ERR_NONE;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_BAD_CTRL;
                    frame_len_d = cycles_to_bytes(cnt_q);
                    state_d     = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (rx_start) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    derr_d  = 1'b0;
                end else if (rx_eof) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Frame FSM and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            derr_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_len_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            derr_q        <= derr_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_len_q   <= frame_len_d;
        end
    end

    // Totals step on the same edge that raises the matching pulse.
    sat_counter #(.WIDTH(16)) u_good_cnt (
        .clk     (clk),
        .i_clr_n (i_rst_n),
        .i_inc   (frame_valid_d),
        .o_count (o_good_cnt)
    );

    sat_counter #(.WIDTH(16)) u_bad_cnt (
        .clk     (clk),
        .i_clr_n (i_rst_n),
        .i_inc   (frame_err_d),
        .o_count (o_bad_cnt)
    );

    assign o_frame_valid = frame_valid_q;
    assign o_frame_err   = frame_err_q;
    assign o_err_code    = err_code_q;
    assign o_frame_len   = frame_len_q;

endmodule

// File: tb/tb_frame_checker.sv
// Bench for frame_checker: directed scenarios plus randomized frame
// streams scored against a frame-level reference model.
module tb_frame_checker;

    localparam int MINC = 5;
    localparam int MAXC = 17;
    localparam logic [63:0] AA_WORD = {8{8'hAA}};

    logic        clk;
    logic        i_rst_n;
    logic [63:0] i_rx_data;
    logic [7:0]  i_rx_ctrl;
    logic        o_frame_valid;
    logic        o_frame_err;
    logic [2:0]  o_err_code;
    logic [15:0] o_frame_len;
    logic [15:0] o_good_cnt;
    logic [15:0] o_bad_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          cyc;
        bit          valid;
        logic [2:0]  code;
        logic [15:0] len;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] sd_q[$];
    logic [7:0]  sc_q[$];

    frame_checker dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_rx_data     (i_rx_data),
        .i_rx_ctrl     (i_rx_ctrl),
        .o_frame_valid (o_frame_valid),
        .o_frame_err   (o_frame_err),
        .o_err_code    (o_err_code),
        .o_frame_len   (o_frame_len),
        .o_good_cnt    (o_good_cnt),
        .o_bad_cnt     (o_bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        @(negedge clk);
        i_rx_data = d;
        i_rx_ctrl = c;
    endtask

    task automatic send_start();
        drive({{7{8'h07}}, 8'hFB}, 8'h01);
    endtask

    task automatic send_eof();
        drive({8'hFD, {7{8'h07}}}, 8'h80);
    endtask

    task automatic send_idle();
        drive({8{8'h07}}, 8'hFF);
    endtask

    task automatic send_data(input int n, input int bad_cyc, input int bad_lane);
        logic [63:0] w;
        for (int k = 0; k < n; k++) begin
            w = AA_WORD;
            if (k == bad_cyc) w[bad_lane*8 +: 8] = 8'h00;
            drive(w, 8'h00);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n   = 1'b0;
        i_rx_data = {8{8'h07}};
        i_rx_ctrl = 8'hFF;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        i_rst_n   = 1'b0;
        i_rx_data = {8{8'h07}};
        i_rx_ctrl = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({o_frame_valid, o_frame_err} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {o_frame_valid, o_frame_err}); else n_pass++;
        n_checks++; if (o_err_code !== 3'd0) $display("FAIL reset_code: got %0d want 0", o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd0) $display("FAIL reset_len: got %0d want 0", o_frame_len); else n_pass++;
        n_checks++; if ({o_good_cnt, o_bad_cnt} !== 32'd0) $display("FAIL reset_cnts: got %0d/%0d want 0/0", o_good_cnt, o_bad_cnt); else n_pass++;
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        do_reset();
        send_start(); send_data(8, -1, 0); send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_err} !== 2'b10) $display("FAIL good_pulse: got %b want 10", {o_frame_valid, o_frame_err}); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd64) $display("FAIL good_len: got %0d want 64", o_frame_len); else n_pass++;
        n_checks++; if (o_err_code !== 3'd0) $display("FAIL good_code: got %0d want 0", o_err_code); else n_pass++;
        n_checks++; if (o_good_cnt !== 16'd1) $display("FAIL good_cnt: got %0d want 1", o_good_cnt); else n_pass++;
        send_idle(); settle();
        n_checks++; if (o_frame_valid !== 1'b0) $display("FAIL good_pulse_width: got %b want 0", o_frame_valid); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd64) $display("FAIL good_len_hold: got %0d want 64", o_frame_len); else n_pass++;
    endtask

    task automatic test_runt();
        do_reset();
        send_start(); send_data(3, -1, 0); send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_err} !== 2'b01) $display("FAIL runt_pulse: got %b want 01", {o_frame_valid, o_frame_err}); else n_pass++;
        n_checks++; if (o_err_code !== 3'd1) $display("FAIL runt_code: got %0d want 1", o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd24) $display("FAIL runt_len: got %0d want 24", o_frame_len); else n_pass++;
        n_checks++; if (o_bad_cnt !== 16'd1) $display("FAIL runt_bad_cnt: got %0d want 1", o_bad_cnt); else n_pass++;
        // zero-length frame
        send_start(); send_eof(); settle();
        n_checks++; if ({o_frame_err, o_err_code} !== 4'b1_001) $display("FAIL zero_len_code: got err=%b code=%0d want err=1 code=1", o_frame_err, o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd0) $display("FAIL zero_len_len: got %0d want 0", o_frame_len); else n_pass++;
    endtask

    task automatic test_oversize();
        do_reset();
        send_start(); send_data(MAXC, -1, 0); settle();
        n_checks++; if (o_frame_err !== 1'b0) $display("FAIL over_early: got %b want 0", o_frame_err); else n_pass++;
        send_data(1, -1, 0); settle();
        n_checks++; if ({o_frame_err, o_err_code} !== 4'b1_010) $display("FAIL over_code: got err=%b code=%0d want err=1 code=2", o_frame_err, o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd144) $display("FAIL over_len: got %0d want 144", o_frame_len); else n_pass++;
        send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_err} !== 2'b00) $display("FAIL over_eof_silent: got %b want 00", {o_frame_valid, o_frame_err}); else n_pass++;
        n_checks++; if (o_bad_cnt !== 16'd1) $display("FAIL over_bad_cnt: got %0d want 1", o_bad_cnt); else n_pass++;
    endtask

    task automatic test_bad_data();
        do_reset();
        send_start(); send_data(6, 2, 3); send_eof(); settle();
        n_checks++; if ({o_frame_err, o_err_code} !== 4'b1_011) $display("FAIL bad_data_code: got err=%b code=%0d want err=1 code=3", o_frame_err, o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd48) $display("FAIL bad_data_len: got %0d want 48", o_frame_len); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_start(); send_data(4, -1, 0); send_start(); settle();
        n_checks++; if ({o_frame_err, o_err_code} !== 4'b1_100) $display("FAIL b2b_ctrl_code: got err=%b code=%0d want err=1 code=4", o_frame_err, o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd32) $display("FAIL b2b_ctrl_len: got %0d want 32", o_frame_len); else n_pass++;
        send_data(5, -1, 0); send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_err, o_err_code} !== 5'b10_000) $display("FAIL b2b_valid: got v=%b e=%b code=%0d want v=1 e=0 code=0", o_frame_valid, o_frame_err, o_err_code); else n_pass++;
        n_checks++; if (o_frame_len !== 16'd40) $display("FAIL b2b_len: got %0d want 40", o_frame_len); else n_pass++;
        n_checks++; if ({o_good_cnt, o_bad_cnt} !== {16'd1, 16'd1}) $display("FAIL b2b_cnts: got %0d/%0d want 1/1", o_good_cnt, o_bad_cnt); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_start(); send_data(8, -1, 0); send_eof();
        send_start(); send_data(3, -1, 0); settle();
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++; if ({o_good_cnt, o_frame_len, o_err_code, o_frame_valid, o_frame_err} !== 37'd0) $display("FAIL midrst_clear: got good=%0d len=%0d code=%0d want all 0", o_good_cnt, o_frame_len, o_err_code); else n_pass++;
        @(negedge clk);
        i_rst_n = 1'b1;
        send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_err} !== 2'b00) $display("FAIL midrst_eof_silent: got %b want 00", {o_frame_valid, o_frame_err}); else n_pass++;
        send_data(6, -1, 0); send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_err, o_frame_len, o_good_cnt, o_bad_cnt} !== 50'd0) $display("FAIL midrst_no_report: got v=%b e=%b len=%0d want 0", o_frame_valid, o_frame_err, o_frame_len); else n_pass++;
        send_start(); send_data(5, -1, 0); send_eof(); settle();
        n_checks++; if ({o_frame_valid, o_frame_len} !== {1'b1, 16'd40}) $display("FAIL midrst_recover: got v=%b len=%0d want v=1 len=40", o_frame_valid, o_frame_len); else n_pass++;
    endtask

    // ---------------- randomized stream with frame-level model ----------------
    task automatic q_push(input logic [63:0] d, input logic [7:0] c);
        sd_q.push_back(d);
        sc_q.push_back(c);
    endtask

    task automatic q_expect(input bit v, input logic [2:0] code, input int ncyc);
        exp_t e;
        e.cyc   = sd_q.size() - 1;
        e.valid = v;
        e.code  = code;
        e.len   = 16'(ncyc * 8);
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] rand_ctrl();
        logic [7:0] c;
        c = 8'($urandom);
        if (c == 8'h00) c = 8'h01;
        return c;
    endfunction

    task automatic q_start();
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[7:0] = 8'hFB;
        if ($urandom_range(0, 3) == 0) w[63:56] = 8'hFD;
        q_push(w, rand_ctrl());
    endtask

    task automatic q_eof();
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (w[7:0] == 8'hFB) w[7:0] = 8'h07;
        w[63:56] = 8'hFD;
        q_push(w, rand_ctrl());
    endtask

    task automatic q_other_ctrl();
        logic [63:0] w;
        w = {$urandom, $urandom};
        if (w[7:0] == 8'hFB) w[7:0] = 8'h07;
        if (w[63:56] == 8'hFD) w[63:56] = 8'h07;
        q_push(w, rand_ctrl());
    endtask

    task automatic build_stream(input int nframes);
        bit open = 0;
        int n, bad, term, gaps;
        logic [63:0] w;
        logic [7:0] b;
        for (int f = 0; f < nframes; f++) begin
            if (!open) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    if ($urandom_range(0, 1) == 0) q_push({$urandom, $urandom}, 8'h00);
                    else q_other_ctrl();
                end
                q_start();
            end
            case ($urandom_range(0, 9))
                0, 1, 2: n = $urandom_range(0, MINC - 1);
                8, 9:    n = $urandom_range(MAXC - 1, MAXC + 3);
                default: n = $urandom_range(MINC, MAXC);
            endcase
            bad = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            term = (f == nframes - 1) ? 0 : int'($urandom_range(0, 9));
            for (int k = 0; k < n; k++) begin
                w = AA_WORD;
                if (k == bad) begin
                    b = 8'($urandom);
                    if (b == 8'hAA) b = 8'h55;
                    w[$urandom_range(0, 7)*8 +: 8] = b;
                end
                q_push(w, 8'h00);
                if (k == MAXC) q_expect(1'b0, 3'd2, MAXC + 1);
            end
            if (term <= 6) begin
                q_eof();
                if (n <= MAXC) begin
                    if (n < MINC)      q_expect(1'b0, 3'd1, n);
                    else if (bad >= 0) q_expect(1'b0, 3'd3, n);
                    else               q_expect(1'b1, 3'd0, n);
                end
                open = 0;
            end else if (term <= 8) begin
                q_start();
                if (n <= MAXC) q_expect(1'b0, 3'd4, n);
                open = 1;
            end else begin
                q_other_ctrl();
                if (n <= MAXC) q_expect(1'b0, 3'd4, n);
                open = 0;
            end
        end
    endtask

    task automatic test_random();
        int exp_good = 0;
        int exp_bad = 0;
        logic [2:0] last_code = 3'd0;
        logic [15:0] last_len = 16'd0;
        bit has, wv, we;
        exp_t e;
        sd_q.delete(); sc_q.delete(); exp_q.delete();
        build_stream(60);
        do_reset();
        for (int i = 0; i < sd_q.size(); i++) begin
            drive(sd_q[i], sc_q[i]);
            settle();
            has = (exp_q.size() > 0) && (exp_q[0].cyc == i);
            wv = 0; we = 0;
            if (has) begin
                e = exp_q.pop_front();
                wv = e.valid;
                we = !e.valid;
                last_code = e.valid ? 3'd0 : e.code;
                last_len  = e.len;
                exp_good += int'(wv);
                exp_bad  += int'(we);
            end
            n_checks++; if ({o_frame_valid, o_frame_err} !== {wv, we}) $display("FAIL rnd_pulse cyc %0d: got %b want %b", i, {o_frame_valid, o_frame_err}, {wv, we}); else n_pass++;
            n_checks++; if (o_err_code !== last_code) $display("FAIL rnd_code cyc %0d: got %0d want %0d", i, o_err_code, last_code); else n_pass++;
            n_checks++; if (o_frame_len !== last_len) $display("FAIL rnd_len cyc %0d: got %0d want %0d", i, o_frame_len, last_len); else n_pass++;
            n_checks++; if ({o_good_cnt, o_bad_cnt} !== {16'(exp_good), 16'(exp_bad)}) $display("FAIL rnd_cnts cyc %0d: got %0d/%0d want %0d/%0d", i, o_good_cnt, o_bad_cnt, exp_good, exp_bad); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rnd_leftover: got %0d unmatched reports want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_runt();
        test_oversize();
        test_bad_data();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_checker.md
FRAME_CHECKER -- requirements
Module: frame_checker

Interface
REQ-001 Parameter DATA_WIDTH, 64: receive data width in bits (8 lanes of 8 bits).
REQ-002 Parameter CTRL_WIDTH, 8: receive control width in bits, one bit per lane.
REQ-003 Parameters IDLE_CODE 8'h07, START_CODE 8'hFB, EOF_CODE 8'hFD: control characters.
REQ-004 Parameter DATA_PATTERN, 8'hAA: expected value of every payload byte.
REQ-005 Parameter MIN_DATA_CYCLES, 5: minimum legal payload cycles (40 bytes).
REQ-006 Parameter MAX_DATA_CYCLES, 17: maximum legal payload cycles (136 bytes).
REQ-007 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 Port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-009 Port i_rx_data, input, DATA_WIDTH: received data word; lane 0 is bits 7:0.
REQ-010 Port i_rx_ctrl, input, CTRL_WIDTH: received control flags.
REQ-011 Port o_frame_valid, output, 1: one-cycle pulse when a good frame completes.
REQ-012 Port o_frame_err, output, 1: one-cycle pulse when a frame is rejected.
REQ-013 Port o_err_code, output, 3: error class for the o_frame_err pulse: 0 none, 1 RUNT, 2 OVERSIZE, 3 BAD_DATA, 4 BAD_CTRL.
REQ-014 Port o_frame_len, output, 16: payload length in bytes for the completed or rejected frame (data cycles x 8).
REQ-015 Ports o_good_cnt and o_bad_cnt, output, 16 each: good and rejected frame totals.

Function
REQ-016 Classification: i_rx_ctrl == 0 is a data cycle; any nonzero i_rx_ctrl is a control cycle.
REQ-017 Control cycle with lane 0 == START_CODE is a START; control cycle with lane 7 == EOF_CODE is an EOF; START takes precedence if both match.
REQ-018 States: IDLE, DATA and DROP; after reset the block is in IDLE.
REQ-019 IDLE: a START moves to DATA and clears the cycle counter and data-error flag; all other cycles are ignored.
REQ-020 DATA, data cycle: counter increments; any byte != DATA_PATTERN sets the sticky data-error flag.
REQ-021 DATA, data cycle with counter already == MAX_DATA_CYCLES: report OVERSIZE with len = (MAX_DATA_CYCLES+1)*8, then move to DROP.
REQ-022 DATA, EOF: if counter < MIN_DATA_CYCLES report RUNT, else if the data-error flag is set report BAD_DATA, else pulse o_frame_valid; then move to IDLE.
REQ-023 DATA, START: report BAD_CTRL for the open frame and start a new frame in the same cycle, staying in DATA with the counter cleared.
REQ-024 DATA, any other control cycle (idle or unknown): report BAD_CTRL and move to IDLE.
REQ-025 DROP: an EOF returns to IDLE silently; a START opens a new frame in DATA; all other cycles are ignored.
REQ-026 A zero-length frame (START immediately followed by EOF) is reported as RUNT with len 0.
REQ-027 Outputs are registered; the pulse, o_err_code and o_frame_len appear exactly one cycle after the deciding input cycle.
REQ-028 o_err_code and o_frame_len hold their last reported values until the next report; o_err_code is 0 on a valid report.
REQ-029 o_good_cnt and o_bad_cnt increment on the cycle their pulse is asserted and saturate at 16'hFFFF.

Reset
REQ-030 Assertion of i_rst_n low immediately forces state IDLE and clears the counter, the data-error flag and all outputs to 0, including mid-frame.
REQ-031 After i_rst_n deasserts, the first report only occurs after a new START has been received.

Structure
REQ-032 Package eth_mii_pkg holds the control-code constants, the state enum and the err_code_t enum; the generator and the checker both import it.
REQ-033 One sub-module, sat_counter (parameterised width, increment enable, asynchronous active-low clear), is instantiated twice for the good and bad totals.

Verification
REQ-034 START, 8 cycles of all-AA data, EOF -> o_frame_valid pulses one cycle after EOF; len 64; good_cnt 1.
REQ-035 START, 3 data cycles, EOF -> o_frame_err pulses; code 1; len 24; bad_cnt 1.
REQ-036 START, 18 data cycles -> OVERSIZE (code 2, len 144) reported after the 18th data cycle; the following EOF produces no report.
REQ-037 START, 6 data cycles with byte 3 of cycle 2 = 8'h00, EOF -> code 3, len 48.
REQ-038 START, 4 data cycles, START, 5 data cycles, EOF -> BAD_CTRL (code 4, len 32) followed by a valid report with len 40.
REQ-039 i_rst_n pulsed low in the middle of a frame, then an EOF arrives -> all outputs read 0 and no pulse is produced.
